mem_sched: RTL and testbench

MEM_SCHED -- requirements
Module: mem_sched

---
 rtl/mem_sched_pkg.sv | 27 ++
 rtl/mem_sched_pick.sv | 27 ++
 rtl/mem_sched.sv | 153 +++++++++++++++
 tb/tb_mem_sched.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// Shared definitions for the memory scheduler: FSM encoding, requester indices
// and the default SRAM window.
package mem_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam int NUM_REQ   = 3;
    localparam int REQ_AXIS  = 0;
    localparam int REQ_AG    = 1;
    localparam int REQ_FETCH = 2;

    localparam logic [15:0] SRAM_BASE_DEF = 16'h8000;

    // A grant is always one-hot; anything else falls back to the AXI slave index.
    function automatic logic [1:0] grant_index(input logic [NUM_REQ-1:0] grant);
        case (grant)
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_sched_pick.sv
// Winner selection: starved requesters first (ag before fetch), otherwise
// fixed priority axis > ag > fetch.
module mem_sched_pick
    import mem_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] val,
    input  logic               starved_ag,
    input  logic               starved_fetch,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        if (val[REQ_AG] && starved_ag) begin
            grant[REQ_AG] = 1'b1;
        end else if (val[REQ_FETCH] && starved_fetch) begin
            grant[REQ_FETCH] = 1'b1;
        end else if (val[REQ_AXIS]) begin
            grant[REQ_AXIS] = 1'b1;
        end else if (val[REQ_AG]) begin
            grant[REQ_AG] = 1'b1;
        end else if (val[REQ_FETCH]) begin
            grant[REQ_FETCH] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_sched.sv
// Three-requester memory scheduler with starvation promotion; a single
// transaction is outstanding at a time to either SRAM or the AXI master.
module mem_sched
    import mem_sched_pkg::*;
#(
    parameter int          STARVE_LIM = 4,
    parameter logic [15:0] SRAM_BASE  = SRAM_BASE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     i_req_val,
    input  logic [32*NUM_REQ-1:0]  i_adr,
    input  logic [32*NUM_REQ-1:0]  i_wdat,
    input  logic [4*NUM_REQ-1:0]   i_wen,
    input  logic [NUM_REQ-1:0]     i_ren,
    output logic [NUM_REQ-1:0]     o_rdy,
    output logic [31:0]            o_rdat,
    output logic                   o_mem_val,
    input  logic                   i_mem_rdy,
    output logic                   o_mem_sram,
    output logic [31:0]            o_mem_adr,
    output logic [31:0]            o_mem_wdat,
    output logic [3:0]             o_mem_wen,
    output logic                   o_mem_ren,
    input  logic                   i_mem_rsp_val,
    input  logic [31:0]            i_mem_rdat,
    output logic                   o_busy
);

    localparam logic [2:0] LIM = 3'(STARVE_LIM);

    state_t             state;
    state_t             next_state;
    logic               arb;
    logic [2:0]         cnt_ag;
    logic [2:0]         cnt_fetch;
    logic [NUM_REQ-1:0] grant;
    logic [1:0]         win;
    logic [1:0]         owner;
    logic [31:0]        sel_adr;
    logic [31:0]        sel_wdat;
    logic [3:0]         sel_wen;
    logic               sel_ren;
    logic [31:0]        adr_q;
    logic [31:0]        wdat_q;
    logic [3:0]         wen_q;
    logic               ren_q;
    logic               sram_q;
    logic               rsp_fire;

    // Losing with val high counts up (saturating); a grant or a dropped val clears.
    function automatic logic [2:0] bump(input logic [2:0] c, input logic v, input logic g);
        if (v && !g) begin
            return (c >= LIM) ? LIM : c + 3'd1;
        end
        return 3'd0;
    endfunction

    mem_sched_pick u_pick (
        .val          (i_req_val),
        .starved_ag   (cnt_ag == LIM),
        .starved_fetch(cnt_fetch == LIM),
        .grant        (grant)
    );

    assign win = grant_index(grant);

    always_comb begin
        case (win)
            2'd0: begin
                sel_adr  = i_adr[32*REQ_AXIS +: 32];
                sel_wdat = i_wdat[32*REQ_AXIS +: 32];
                sel_wen  = i_wen[4*REQ_AXIS +: 4];
                sel_ren  = i_ren[REQ_AXIS];
            end
            2'd1: begin
                sel_adr  = i_adr[32*REQ_AG +: 32];
                sel_wdat = i_wdat[32*REQ_AG +: 32];
                sel_wen  = i_wen[4*REQ_AG +: 4];
                sel_ren  = i_ren[REQ_AG];
            end
            default: begin
                sel_adr  = i_adr[32*REQ_FETCH +: 32];
                sel_wdat = i_wdat[32*REQ_FETCH +: 32];
                sel_wen  = i_wen[4*REQ_FETCH +: 4];
                sel_ren  = i_ren[REQ_FETCH];
            end
        endcase
    end

    always_comb begin
        next_state = state;
        arb        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|i_req_val) begin
                    arb        = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_mem_rdy) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_mem_rsp_val) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt_ag    <= 3'd0;
            cnt_fetch <= 3'd0;
            owner     <= 2'd0;
            adr_q     <= '0;
            wdat_q    <= '0;
            wen_q     <= '0;
            ren_q     <= 1'b0;
            sram_q    <= 1'b0;
        end else begin
            state <= next_state;
            if (arb) begin
                owner     <= win;
                adr_q     <= sel_adr;
                wdat_q    <= sel_wdat;
                wen_q     <= sel_wen;
                ren_q     <= sel_ren;
                sram_q    <= (sel_adr[31:16] == SRAM_BASE);
                cnt_ag    <= bump(cnt_ag, i_req_val[REQ_AG], grant[REQ_AG]);
                cnt_fetch <= bump(cnt_fetch, i_req_val[REQ_FETCH], grant[REQ_FETCH]);
            end
        end
    end

    // Completion is combinational so the owner sees data in the response cycle.
    assign rsp_fire   = (state == ST_WAIT) && i_mem_rsp_val && !rst;
    assign o_rdy      = rsp_fire ? (3'b001 << owner) : 3'b000;
    assign o_rdat     = rsp_fire ? i_mem_rdat : 32'd0;
    assign o_busy     = (state != ST_IDLE);
    assign o_mem_val  = (state == ST_ISSUE);
    assign o_mem_sram = sram_q;
    assign o_mem_adr  = adr_q;
    assign o_mem_wdat = wdat_q;
    assign o_mem_wen  = wen_q;
    assign o_mem_ren  = ren_q;

endmodule

// File: tb/tb_mem_sched.sv
// Self-checking bench for mem_sched: directed vector table, hand-built corner
// sequences and a randomized run against a transaction-level model.
module tb_mem_sched;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_val;
    logic [95:0] req_adr;
    logic [95:0] req_wdat;
    logic [11:0] req_wen;
    logic [2:0]  req_ren;
    logic [2:0]  rdy;
    logic [31:0] rdat;
    logic        mem_val;
    logic        mem_rdy;
    logic        mem_sram;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdat;
    logic [3:0]  mem_wen;
    logic        mem_ren;
    logic        mem_rsp_val;
    logic [31:0] mem_rdat;
    logic        busy;

    int num_checks = 0;
    int num_pass   = 0;

    mem_sched #(.STARVE_LIM(LIM), .SRAM_BASE(16'h8000)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_val    (req_val),
        .i_adr        (req_adr),
        .i_wdat       (req_wdat),
        .i_wen        (req_wen),
        .i_ren        (req_ren),
        .o_rdy        (rdy),
        .o_rdat       (rdat),
        .o_mem_val    (mem_val),
        .i_mem_rdy    (mem_rdy),
        .o_mem_sram   (mem_sram),
        .o_mem_adr    (mem_adr),
        .o_mem_wdat   (mem_wdat),
        .o_mem_wen    (mem_wen),
        .o_mem_ren    (mem_ren),
        .i_mem_rsp_val(mem_rsp_val),
        .i_mem_rdat   (mem_rdat),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          who;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  wen;
        logic        ren;
        logic [31:0] mrdat;
        logic        exp_sram;
        logic [2:0]  exp_rdy;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act === exp) num_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic [2:0] val, input logic mrdy, input logic rsp,
                                 input logic [31:0] md);
        req_val     = val;
        mem_rdy     = mrdy;
        mem_rsp_val = rsp;
        mem_rdat    = md;
    endtask

    task automatic setReq(input int n, input logic [31:0] adr, input logic [31:0] wdat,
                          input logic [3:0] wen, input logic ren);
        req_adr[32*n +: 32] = adr;
        req_wdat[32*n +: 32] = wdat;
        req_wen[4*n +: 4]   = wen;
        req_ren[n]          = ren;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst      = 1'b1;
        req_adr  = '0;
        req_wdat = '0;
        req_wen  = '0;
        req_ren  = '0;
        applyStimulus(3'b000, 1'b0, 1'b0, 32'd0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        #2;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset mem_val", mem_val, 0);
        checkOutput("reset rdy", rdy, 0);
        checkOutput("reset rdat", rdat, 0);
        checkOutput("reset mem_adr", mem_adr, 0);
        checkOutput("reset mem_wen", mem_wen, 0);
    endtask

    // One full transaction with all three requesters held and an instant memory.
    task automatic grantRound(input int who, input string tag);
        logic [2:0] oh;
        oh = 3'b001 << who;
        applyStimulus(3'b111, 1'b1, 1'b1, 32'h0000_0100 + 32'(who));
        #2;
        checkOutput({tag, " idle busy"}, busy, 0);
        checkOutput({tag, " idle rdy"}, rdy, 0);
        nextCycle();
        #2;
        checkOutput({tag, " issue adr"}, mem_adr, 32'h8000_0000 + 32'(who * 4));
        nextCycle();
        #2;
        checkOutput({tag, " grant"}, rdy, oh);
        checkOutput({tag, " rdat"}, rdat, 32'h0000_0100 + 32'(who));
        nextCycle();
    endtask

    vec_t tbl[5];

    // Behavioural model state for the randomized phase.
    int          lost[3];
    int          phase;
    int          owner;
    logic        pend[3];
    logic [31:0] padr[3];
    logic [31:0] pwdat[3];
    logic [3:0]  pwen[3];
    logic        pren[3];

    initial begin
        int order1[6];
        int order2[5];
        logic [31:0] r;
        logic [2:0]  v;
        logic        mrdy;
        logic        rsp;
        logic [31:0] md;

        tbl[0] = '{2, 32'h8000_0010, 32'h0,         4'b0000, 1'b1, 32'hDEAD_BEEF, 1'b1, 3'b100};
        tbl[1] = '{1, 32'h8000_0100, 32'h1234_5678, 4'b0011, 1'b0, 32'h5555_AAAA, 1'b1, 3'b010};
        tbl[2] = '{0, 32'h4000_0000, 32'h0,         4'b0000, 1'b1, 32'hCAFE_F00D, 1'b0, 3'b001};
        tbl[3] = '{2, 32'h8001_0000, 32'h0,         4'b0000, 1'b1, 32'h0123_4567, 1'b0, 3'b100};
        tbl[4] = '{0, 32'h7FFF_FFFC, 32'hA5A5_A5A5, 4'b1111, 1'b0, 32'hFFFF_FFFF, 1'b0, 3'b001};

        $display("[TB] reset and directed vectors");
        doReset();
        for (int i = 0; i < 5; i++) begin
            req_adr  = '0;
            req_wdat = '0;
            req_wen  = '0;
            req_ren  = '0;
            setReq(tbl[i].who, tbl[i].adr, tbl[i].wdat, tbl[i].wen, tbl[i].ren);
            applyStimulus(3'b001 << tbl[i].who, 1'b1, 1'b1, tbl[i].mrdat);
            #2;
            checkOutput("vec idle rdy", rdy, 0);
            checkOutput("vec idle mem_val", mem_val, 0);
            nextCycle();
            #2;
            checkOutput("vec issue mem_val", mem_val, 1);
            checkOutput("vec issue busy", busy, 1);
            checkOutput("vec issue adr", mem_adr, tbl[i].adr);
            checkOutput("vec issue wdat", mem_wdat, tbl[i].wdat);
            checkOutput("vec issue wen", mem_wen, tbl[i].wen);
            checkOutput("vec issue ren", mem_ren, tbl[i].ren);
            checkOutput("vec issue sram", mem_sram, tbl[i].exp_sram);
            checkOutput("vec issue rdy", rdy, 0);
            nextCycle();
            #2;
            checkOutput("vec done rdy", rdy, tbl[i].exp_rdy);
            checkOutput("vec done rdat", rdat, tbl[i].mrdat);
            nextCycle();
            applyStimulus(3'b000, 1'b0, 1'b0, 32'd0);
            #2;
            checkOutput("vec after busy", busy, 0);
            checkOutput("vec after rdy", rdy, 0);
            nextCycle();
        end

        $display("[TB] starvation sequence");
        doReset();
        for (int n = 0; n < 3; n++) setReq(n, 32'h8000_0000 + 32'(n * 4), 32'd0, 4'd0, 1'b1);
        order1 = '{0, 0, 0, 0, 1, 2};
        for (int k = 0; k < 6; k++) grantRound(order1[k], "starve");

        $display("[TB] backpressure and spurious response");
        doReset();
        setReq(1, 32'h4000_0000, 32'd0, 4'd0, 1'b1);
        applyStimulus(3'b010, 1'b0, 1'b0, 32'd0);
        nextCycle();
        for (int c = 0; c < 5; c++) begin
            applyStimulus(3'b010, 1'b0, c == 2, 32'hBAD0_0BAD);
            #2;
            checkOutput("bp mem_val", mem_val, 1);
            checkOutput("bp adr", mem_adr, 32'h4000_0000);
            checkOutput("bp sram", mem_sram, 0);
            checkOutput("bp ren", mem_ren, 1);
            checkOutput("bp rdy", rdy, 0);
            checkOutput("bp rdat", rdat, 0);
            nextCycle();
        end
        applyStimulus(3'b010, 1'b1, 1'b0, 32'd0);
        #2;
        checkOutput("bp accept mem_val", mem_val, 1);
        nextCycle();
        applyStimulus(3'b000, 1'b0, 1'b0, 32'd0);
        #2;
        checkOutput("bp wait rdy", rdy, 0);
        checkOutput("bp wait mem_val", mem_val, 0);
        checkOutput("bp wait busy", busy, 1);
        nextCycle();
        applyStimulus(3'b000, 1'b0, 1'b1, 32'h600D_F00D);
        #2;
        checkOutput("bp done rdy", rdy, 3'b010);
        checkOutput("bp done rdat", rdat, 32'h600D_F00D);
        nextCycle();
        applyStimulus(3'b000, 1'b0, 1'b1, 32'h600D_F00D);
        #2;
        checkOutput("bp idle rsp ignored", rdy, 0);
        nextCycle();

        $display("[TB] reset while waiting");
        doReset();
        for (int n = 0; n < 3; n++) setReq(n, 32'h8000_0000 + 32'(n * 4), 32'd0, 4'd0, 1'b1);
        grantRound(0, "pre");
        grantRound(0, "pre");
        applyStimulus(3'b111, 1'b1, 1'b0, 32'd0);
        nextCycle();
        nextCycle();
        #2;
        checkOutput("rstw wait busy", busy, 1);
        rst = 1'b1;
        applyStimulus(3'b000, 1'b0, 1'b1, 32'h1111_1111);
        #2;
        checkOutput("rstw during rdy", rdy, 0);
        nextCycle();
        rst = 1'b0;
        #2;
        checkOutput("rstw stale rdy", rdy, 0);
        checkOutput("rstw stale rdat", rdat, 0);
        checkOutput("rstw busy", busy, 0);
        checkOutput("rstw mem_val", mem_val, 0);
        nextCycle();
        order2 = '{0, 0, 0, 0, 1};
        for (int k = 0; k < 5; k++) grantRound(order2[k], "post");

        $display("[TB] randomized run");
        doReset();
        phase = 0;
        owner = 0;
        for (int n = 0; n < 3; n++) begin
            lost[n] = 0;
            pend[n] = 1'b0;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int n = 0; n < 3; n++) begin
                if (!pend[n] && $urandom_range(0, 99) < 40) begin
                    r        = $urandom;
                    pend[n]  = 1'b1;
                    padr[n]  = {($urandom_range(0, 1) == 1) ? 16'h8000 : r[31:16], r[15:0]};
                    pwdat[n] = $urandom;
                    pwen[n]  = 4'($urandom_range(0, 15));
                    pren[n]  = (pwen[n] == 4'd0);
                    setReq(n, padr[n], pwdat[n], pwen[n], pren[n]);
                end
            end
            v    = {pend[2], pend[1], pend[0]};
            mrdy = ($urandom_range(0, 1) == 1);
            rsp  = ($urandom_range(0, 2) == 0);
            md   = $urandom;
            applyStimulus(v, mrdy, rsp, md);
            #2;
            checkOutput("rnd busy", busy, phase != 0);
            checkOutput("rnd mem_val", mem_val, phase == 1);
            if (phase == 1) begin
                checkOutput("rnd adr", mem_adr, padr[owner]);
                checkOutput("rnd wdat", mem_wdat, pwdat[owner]);
                checkOutput("rnd wen", mem_wen, pwen[owner]);
                checkOutput("rnd ren", mem_ren, pren[owner]);
                checkOutput("rnd sram", mem_sram, padr[owner][31:16] == 16'h8000);
            end
            if (phase == 2 && rsp) begin
                checkOutput("rnd rdy", rdy, 3'b001 << owner);
                checkOutput("rnd rdat", rdat, md);
            end else begin
                checkOutput("rnd idle rdy", rdy, 0);
                checkOutput("rnd idle rdat", rdat, 0);
            end
            case (phase)
                0: if (v != 3'b000) begin
                    if (v[1] && lost[1] >= LIM)      owner = 1;
                    else if (v[2] && lost[2] >= LIM) owner = 2;
                    else if (v[0])                   owner = 0;
                    else if (v[1])                   owner = 1;
                    else                             owner = 2;
                    for (int n = 1; n < 3; n++) begin
                        if (v[n] && n != owner) lost[n] = (lost[n] + 1 > LIM) ? LIM : lost[n] + 1;
                        else                    lost[n] = 0;
                    end
                    phase = 1;
                end
                1: if (mrdy) phase = 2;
                default: if (rsp) begin
                    pend[owner] = 1'b0;
                    phase = 0;
                end
            endcase
            nextCycle();
        end

        $display("%0d/%0d checks passed", num_pass, num_checks);
        $finish;
    end

endmodule
